// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD command sequencer:
// FSM state encoding, controller opcodes and the power-up init ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        IDLE     = 3'd1,
        SETUP    = 3'd2,
        EN_HIGH  = 3'd3,
        EXEC     = 3'd4
    } state_e;

    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] HOME         = 8'h02;
    localparam logic [7:0] FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] DISP_ON      = 8'h0C;
    localparam logic [7:0] ENTRY_INC    = 8'h06;

    localparam int INIT_LEN = 6;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] val;
        case (idx)
            3'd0:    val = FUNC_8BIT_2L;
            3'd1:    val = FUNC_8BIT_2L;
            3'd2:    val = FUNC_8BIT_2L;
            3'd3:    val = DISP_ON;
            3'd4:    val = CLEAR;
            3'd5:    val = ENTRY_INC;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    // Clear and Home (0x02, and 0x03 which the controller decodes as Home) run ~40x longer.
    function automatic logic is_long_exec(input logic rs, input logic [7:0] db);
        return !rs && ((db == CLEAR) || (db == HOME) || (db == (HOME | 8'h01)));
    endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Requester-to-sequencer byte handshake: one byte moves when cmd_valid and cmd_ready are both high.
interface lcd_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter: a load of N makes expired rise N cycles later and stay for one cycle
// unless reloaded. Load takes priority over reset so the sequencer can arm the power-up wait in reset.
module lcd_wait_timer #(
    parameter int TW = 23
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expired
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && !load) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TW'(1));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 bus sequencer: autonomous power-up init, then one requester byte at a time
// with RS/DB setup, E pulse and execution hold-off, all timed by a single shared wait timer.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 3,
    parameter int T_PULSE   = 12,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int TW        = 23
) (
    input  logic                CLK,
    input  logic                RST,
    lcd_cmd_sequencer_if.slave  cmd,
    output logic                init_done,
    output logic                busy,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_en,
    output logic [7:0]          lcd_db
);

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic [7:0]    lcd_db_q, lcd_db_d;
    logic          init_done_q, init_done_d;
    logic          busy_q, busy_d;
    logic          cmd_rdy;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;

    lcd_wait_timer #(.TW(TW)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign cmd_rdy = (state_q == IDLE) && init_done_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_db_d    = lcd_db_q;
        init_done_d = init_done_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            PWR_WAIT: begin
                if (tmr_expired) begin
                    lcd_rs_d = 1'b0;
                    lcd_db_d = init_rom(idx_q);
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_SETUP);
                end
            end
            IDLE: begin
                if (cmd.cmd_valid && cmd_rdy) begin
                    lcd_rs_d = cmd.cmd_rs;
                    lcd_db_d = cmd.cmd_data;
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_SETUP);
                end
            end
            SETUP: begin
                if (tmr_expired) begin
                    state_d  = EN_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_PULSE);
                end
            end
            EN_HIGH: begin
                if (tmr_expired) begin
                    state_d  = EXEC;
                    tmr_load = 1'b1;
                    tmr_val  = is_long_exec(lcd_rs_q, lcd_db_q) ? TW'(T_CLEAR) : TW'(T_CMD);
                end
            end
            EXEC: begin
                if (tmr_expired) begin
                    if (init_done_q) begin
                        state_d = IDLE;
                    end else if (idx_q == 3'(INIT_LEN - 1)) begin
                        idx_d       = 3'(INIT_LEN);
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        lcd_rs_d = 1'b0;
                        lcd_db_d = init_rom(idx_q + 3'd1);
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(T_SETUP);
                    end
                end
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase

        // Arming the power-up wait on the reset edge makes PWR_WAIT last exactly T_POWERUP cycles.
        if (RST) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(T_POWERUP);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= PWR_WAIT;
            idx_q       <= 3'd0;
            lcd_rs_q    <= 1'b0;
            lcd_db_q    <= 8'h00;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_db_q    <= lcd_db_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd.cmd_ready = cmd_rdy;
    assign init_done     = init_done_q;
    assign busy          = busy_q;
    assign lcd_rs        = lcd_rs_q;
    assign lcd_rw        = 1'b0;
    assign lcd_en        = (state_q == EN_HIGH);
    assign lcd_db        = lcd_db_q;

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Controller that sequences the HD44780-style character LCD bus on the C5G board.
- After reset it runs the LCD power-up init sequence autonomously, then accepts command/data bytes from a requester over a valid/ready handshake.
- For each byte it generates the RS/E/DB timing and holds off for the command's execution time.
- All delays come from one shared wait-timer sub-module that the sequencer loads and polls.

Parameters:
- T_POWERUP, 750000, cycles of power-up wait before the first init write (15 ms @ 50 MHz).
- T_SETUP, 3, cycles with RS/DB stable and E low before the E rising edge.
- T_PULSE, 12, cycles E is held high.
- T_CMD, 2000, execution wait after a normal write (40 us).
- T_CLEAR, 82000, execution wait after Clear (0x01) or Home (0x02/0x03) with RS=0 (1.64 ms).
- TW, 23, timer width; every T_* value must be >=1 and <2^TW.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  requester has a byte.
- cmd_ready  out  1  sequencer accepts a byte this cycle.
- cmd_rs  in  1  0 = command register, 1 = data register.
- cmd_data  in  8  byte to write.
- init_done  out  1  init sequence complete; stays high until reset.
- busy  out  1  a write or wait is in progress.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; tied 0, write only.
- lcd_en  out  1  LCD enable strobe.
- lcd_db  out  8  LCD data bus.

Behaviour:
- Reset (RST high at a CLK edge):
  - State goes to PWR_WAIT; init index goes to 0.
  - Timer is loaded with T_POWERUP.
  - All outputs are 0: cmd_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en, lcd_db.
  - Reset mid-write drops lcd_en at that edge and restarts the full init. No partial write resumes.
- Timer contract: a load of N at edge k asserts expired from the cycle after edge k+N-1, so each phase lasts exactly N cycles. A reload restarts the count.
- States:
  - PWR_WAIT: busy=1. On expired, go to SETUP with the init ROM entry selected.
  - IDLE: cmd_ready=1 and busy=0, only when init_done=1. On cmd_valid&&cmd_ready, latch cmd_rs/cmd_data into lcd_rs/lcd_db and go to SETUP. cmd_ready falls in the same cycle the state leaves IDLE, so at most one byte is accepted.
  - SETUP: lcd_en=0; lcd_rs/lcd_db hold the latched values. Lasts T_SETUP cycles, then EN_HIGH.
  - EN_HIGH: lcd_en=1 for exactly T_PULSE cycles. Then EXEC.
  - EXEC: lcd_en=0; RS/DB are held. Wait T_CLEAR if RS=0 and DB is 0x01, 0x02 or 0x03; otherwise wait T_CMD.
  - On EXEC expiry during init: increment the index. If index < 6, go to SETUP with the next entry. If index = 6, set init_done=1 and go to IDLE.
  - On EXEC expiry after init: go to IDLE.
- Init ROM (all RS=0), in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. The 0x01 entry uses T_CLEAR.
- Per-write timing: latency from accept to lcd_en rising is T_SETUP+1 cycles (the accept edge plus T_SETUP). Total occupancy is T_SETUP+T_PULSE+T_exec cycles. cmd_ready returns one cycle after EXEC expiry.
- cmd_valid while not ready: ignored. The requester must hold cmd_valid and cmd_data until the handshake completes.
- lcd_db and lcd_rs change only on the accept edge or on an init-entry load, never while lcd_en=1.
- busy = (state != IDLE).

Decomposition:
- Shared package lcd_pkg holds:
  - state encoding constants (PWR_WAIT, IDLE, SETUP, EN_HIGH, EXEC);
  - the init ROM contents and its length constant (6);
  - HD44780 opcode constants (CLEAR=0x01, HOME=0x02, FUNC_8BIT_2L=0x38, DISP_ON=0x0C, ENTRY_INC=0x06).
- One sub-module, lcd_wait_timer:
  - ports: CLK, RST, load, load_val[TW-1:0], expired;
  - down-counter, reset value 0 with expired=0.

Test Plan:
- Sim parameters for all scenarios: T_POWERUP=20, T_SETUP=2, T_PULSE=4, T_CMD=10, T_CLEAR=30.
- Reset release -> lcd_en stays 0 for 20 cycles. Six E pulses follow, each exactly 4 cycles high, with lcd_db = 38,38,38,0C,01,06 and lcd_rs=0. The gap after 0x01 is 30 cycles; other gaps are 10. init_done rises once.
- After init, present cmd_rs=1, cmd_data=0x41 -> accepted in 1 cycle and lcd_en rises 3 cycles later with lcd_db=0x41 and lcd_rs=1. cmd_ready returns 16 cycles after accept.
- Back-to-back cmd_valid held high with 0x48 then 0x49 -> exactly two pulses. The second is accepted only when cmd_ready is 1, and no byte is lost or duplicated.
- Command 0x01 with RS=0 -> 30-cycle exec wait. Command 0x01 with RS=1 -> 10-cycle wait.
- Assert RST while lcd_en=1 during the third init write -> lcd_en=0 at the next edge and all outputs are 0. The full 20-cycle power-up wait and the init sequence then repeat from entry 0.
- cmd_valid pulsed during init -> no accept and cmd_ready stays 0. lcd_rw stays 0 throughout every scenario.
